// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues reads to a 1-cycle synchronous
// instruction memory and presents fetch_instr/fetch_pc/fetch_valid to decode.
// A halt freezes the stage and parks any in-flight response in a one-entry skid.
// A taken branch redirects the PC, drops everything in flight and inserts a bubble.
// Optional feature macro: FETCH_MISALIGN_CHK_EN. When it is defined, fetch_misalign
// pulses for one cycle after a redirect to a target whose low two bits are non-zero.
module fetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            halt_fetch,
    input  logic            taken_branch,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] fetch_instr,
    output logic [XLEN-1:0] fetch_pc,
    output logic            fetch_valid,
    output logic            fetch_misalign
);

    typedef enum logic [1:0] {IDLE, RUN, STALL, FLUSH} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            rsp_pend_q, rsp_pend_d;
    logic [XLEN-1:0] fetch_instr_q, fetch_instr_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic [XLEN-1:0] skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic            skid_valid_q, skid_valid_d;
    logic            issue;
`ifdef FETCH_MISALIGN_CHK_EN
    logic            misalign_q, misalign_d;
`endif

    // Next-state and request logic; branch outranks halt, halt outranks normal flow.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        rsp_pend_d    = rsp_pend_q;
        fetch_instr_d = fetch_instr_q;
        fetch_pc_d    = fetch_pc_q;
        fetch_valid_d = fetch_valid_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        skid_valid_d  = skid_valid_q;
        issue         = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        misalign_d    = 1'b0;
`endif
        if (taken_branch) begin
            pc_d          = branch_target & ~XLEN'(3);
            skid_valid_d  = 1'b0;
            rsp_pend_d    = 1'b0;
            fetch_instr_d = NOP_INSTR;
            fetch_valid_d = 1'b0;
            state_d       = FLUSH;
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_d    = |branch_target[1:0];
`endif
        end else if (halt_fetch) begin
            state_d = STALL;
            // The response for the last request arrives now; park it so it is not lost.
            if (rsp_pend_q) begin
                skid_instr_d = imem_rdata;
                skid_pc_d    = req_pc_q;
                skid_valid_d = 1'b1;
                rsp_pend_d   = 1'b0;
            end
        end else begin
            unique case (state_q)
                IDLE, FLUSH: state_d = RUN;
                RUN: begin
                    issue = 1'b1;
                    if (rsp_pend_q) begin
                        fetch_instr_d = imem_rdata;
                        fetch_pc_d    = req_pc_q;
                        fetch_valid_d = 1'b1;
                    end
                end
                STALL: begin
                    issue   = 1'b1;
                    state_d = RUN;
                    if (skid_valid_q) begin
                        fetch_instr_d = skid_instr_q;
                        fetch_pc_d    = skid_pc_q;
                        fetch_valid_d = 1'b1;
                        skid_valid_d  = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (issue) begin
                pc_d       = pc_q + XLEN'(4);
                req_pc_d   = pc_q;
                rsp_pend_d = 1'b1;
            end
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            req_pc_q      <= '0;
            rsp_pend_q    <= 1'b0;
            fetch_instr_q <= NOP_INSTR;
            fetch_pc_q    <= '0;
            fetch_valid_q <= 1'b0;
            skid_instr_q  <= '0;
            skid_pc_q     <= '0;
            skid_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            rsp_pend_q    <= rsp_pend_d;
            fetch_instr_q <= fetch_instr_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_valid_q <= fetch_valid_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
            skid_valid_q  <= skid_valid_d;
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    // One-cycle misaligned-target flag, raised the cycle after the redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign fetch_misalign = misalign_q;
`else
    assign fetch_misalign = 1'b0;
`endif

    assign imem_req    = issue;
    assign imem_addr   = pc_q;
    assign fetch_instr = fetch_instr_q;
    assign fetch_pc    = fetch_pc_q;
    assign fetch_valid = fetch_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a directed vector table covering start-up, halt with
// in-flight response, branch, branch+halt, misaligned target and PC wrap, then
// randomized halt/branch traffic with a mid-stream asynchronous reset, all
// compared against a queue-based reference model of the fetch stream.
module tb_fetch_stage;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef FETCH_MISALIGN_CHK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halt_fetch = 1'b0;
    logic        taken_branch = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic        fetch_misalign;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .XLEN      (32),
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .halt_fetch     (halt_fetch),
        .taken_branch   (taken_branch),
        .branch_target  (branch_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .fetch_instr    (fetch_instr),
        .fetch_pc       (fetch_pc),
        .fetch_valid    (fetch_valid),
        .fetch_misalign (fetch_misalign)
    );

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hC0DE_5000;
    endfunction

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= memf(imem_addr);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: next address to fetch, queue of requested-but-undelivered
    // addresses, the visible output, and a flag for the one quiet cycle that
    // follows reset or a redirect.
    logic [31:0] m_pc, m_instr, m_fpc;
    bit          m_valid, m_mis, m_quiet;
    logic [31:0] m_pend[$];

    task automatic model_reset();
        m_pc = RST_PC; m_instr = NOP; m_fpc = '0; m_valid = 0; m_mis = 0; m_quiet = 1;
        m_pend.delete();
    endtask

    function automatic bit m_issue();
        return !taken_branch && !halt_fetch && !m_quiet;
    endfunction

    task automatic model_edge();
        logic [31:0] a;
        if (taken_branch) begin
            m_pend.delete();
            m_pc = branch_target & 32'hFFFF_FFFC;
            m_instr = NOP; m_valid = 0;
            m_mis = MIS_EN && (branch_target[1:0] != 2'b00);
            m_quiet = 1;
        end else begin
            m_mis = 0;
            if (!halt_fetch && !m_quiet) begin
                if (m_pend.size() > 0) begin
                    a = m_pend.pop_front();
                    m_instr = memf(a); m_fpc = a; m_valid = 1;
                end
                m_pend.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
            m_quiet = 0;
        end
    endtask

    // Drive one cycle's inputs and compare against the model on the falling edge.
    task automatic step(input bit h, input bit b, input logic [31:0] t);
        halt_fetch = h; taken_branch = b; branch_target = t;
        @(negedge clk);
        chk("m_imem_req",    imem_req, m_issue());
        chk("m_imem_addr",   imem_addr, m_pc);
        chk("m_fetch_instr", fetch_instr, m_instr);
        chk("m_fetch_pc",    fetch_pc, m_fpc);
        chk("m_fetch_valid", fetch_valid, m_valid);
        chk("m_misalign",    fetch_misalign, m_mis);
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_imem_req"},    imem_req, 1'b0);
        chk({tag, "_imem_addr"},   imem_addr, RST_PC);
        chk({tag, "_fetch_instr"}, fetch_instr, NOP);
        chk({tag, "_fetch_pc"},    fetch_pc, 32'h0);
        chk({tag, "_fetch_valid"}, fetch_valid, 1'b0);
        chk({tag, "_misalign"},    fetch_misalign, 1'b0);
    endtask

    typedef struct {
        bit          h;
        bit          b;
        logic [31:0] t;
        bit          req;
        logic [31:0] addr;
        bit          v;
        logic [31:0] pc;
        bit          mis;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit h, input bit b, input logic [31:0] t, input bit req,
                       input logic [31:0] addr, input bit v, input logic [31:0] pc, input bit mis);
        vec_t r;
        r.h = h; r.b = b; r.t = t; r.req = req; r.addr = addr; r.v = v; r.pc = pc; r.mis = mis;
        tbl.push_back(r);
    endtask

    initial begin
        //  h  b  target        req addr          v  fetch_pc      mis(if enabled)
        add(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0); // IDLE
        add(0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        0);
        add(0, 0, 32'h0,        1, 32'h4,        0, 32'h0,        0);
        add(0, 0, 32'h0,        1, 32'h8,        1, 32'h0,        0); // first valid
        add(1, 0, 32'h0,        0, 32'hC,        1, 32'h4,        0); // 0x8 in flight
        add(1, 0, 32'h0,        0, 32'hC,        1, 32'h4,        0);
        add(1, 0, 32'h0,        0, 32'hC,        1, 32'h4,        0);
        add(0, 0, 32'h0,        1, 32'hC,        1, 32'h4,        0); // release
        add(0, 0, 32'h0,        1, 32'h10,       1, 32'h8,        0); // skid drained
        add(0, 0, 32'h0,        1, 32'h14,       1, 32'hC,        0);
        add(0, 0, 32'h0,        1, 32'h18,       1, 32'h10,       0);
        add(0, 0, 32'h0,        1, 32'h1C,       1, 32'h14,       0);
        add(0, 1, 32'h100,      0, 32'h20,       1, 32'h18,       0); // branch at pc 0x20
        add(0, 0, 32'h0,        0, 32'h100,      0, 32'h18,       0); // FLUSH bubble
        add(0, 0, 32'h0,        1, 32'h100,      0, 32'h18,       0);
        add(0, 0, 32'h0,        1, 32'h104,      0, 32'h18,       0);
        add(0, 0, 32'h0,        1, 32'h108,      1, 32'h100,      0); // target arrives
        add(1, 1, 32'h300,      0, 32'h10C,      1, 32'h104,      0); // branch + halt
        add(1, 0, 32'h0,        0, 32'h300,      0, 32'h104,      0);
        add(1, 0, 32'h0,        0, 32'h300,      0, 32'h104,      0);
        add(0, 0, 32'h0,        1, 32'h300,      0, 32'h104,      0); // release, no skid
        add(0, 0, 32'h0,        1, 32'h304,      0, 32'h104,      0);
        add(0, 0, 32'h0,        1, 32'h308,      1, 32'h300,      0);
        add(0, 1, 32'hFFFF_FFFE,0, 32'h30C,      1, 32'h304,      0); // misaligned target
        add(0, 0, 32'h0,        0, 32'hFFFF_FFFC,0, 32'h304,      1);
        add(0, 0, 32'h0,        1, 32'hFFFF_FFFC,0, 32'h304,      0);
        add(0, 0, 32'h0,        1, 32'h0,        0, 32'h304,      0); // PC wrapped
        add(0, 0, 32'h0,        1, 32'h4,        1, 32'hFFFF_FFFC,0);
        add(1, 0, 32'h0,        0, 32'h8,        1, 32'h0,        0); // one-cycle halt
        add(0, 0, 32'h0,        1, 32'h8,        1, 32'h0,        0);
        add(0, 0, 32'h0,        1, 32'hC,        1, 32'h4,        0);
        add(0, 0, 32'h0,        1, 32'h10,       1, 32'h8,        0);

        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].h, tbl[i].b, tbl[i].t);
            chk("v_imem_req",    imem_req, tbl[i].req);
            chk("v_imem_addr",   imem_addr, tbl[i].addr);
            chk("v_fetch_valid", fetch_valid, tbl[i].v);
            chk("v_fetch_pc",    fetch_pc, tbl[i].pc);
            chk("v_fetch_instr", fetch_instr, tbl[i].v ? memf(tbl[i].pc) : NOP);
            chk("v_misalign",    fetch_misalign, tbl[i].mis & MIS_EN);
            advance();
        end

        for (int c = 0; c < 3000; c++) begin
            logic [31:0] t;
            if (c == 1500) begin
                // Asynchronous reset asserted mid-cycle in the middle of traffic.
                halt_fetch = 1'b0; taken_branch = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                chk_reset_outputs("async_reset");
                rst_n = 1'b1;
                model_reset();
            end
            t = $urandom;
            if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
            step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, t);
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
